// File: rtl/axi_hdr_pkg.sv
// axi_hdr_pkg: shared types and defaults for the header arbiter slice
package axi_hdr_pkg;
  typedef enum logic [1:0] {IDLE, OFFER, WAIT_LAST} state_e;
  localparam int NUM_REQ_DEF = 4;
  localparam int PTR_WD = $clog2(NUM_REQ_DEF);
endpackage

// File: rtl/axi_hdr_rr_pick.sv
// axi_hdr_rr_pick: round-robin pick of the first request at or above ptr_i, wrapping
module axi_hdr_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  assign any_o  = |req_i;
  assign pick_o = any_o ? N'(1) << idx_o : '0;
  // Scan from the farthest offset down so the closest one to ptr_i wins.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % N]) idx_o = PW'((int'(ptr_i) + i) % N);
  end
endmodule

// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin share of the insert block's header port,
// one grant per packet, released on the snooped last_out handshake.
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int CNT_WD       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              valid_hdr,
  input  logic [NUM_REQ*DATA_WD-1:0]      data_hdr,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] keep_hdr,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  cnt_hdr,
  output logic [NUM_REQ-1:0]              ready_hdr,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            valid_out,
  input  logic                            ready_out,
  input  logic                            last_out,
  output logic [NUM_REQ-1:0]              grant,
  output logic [CNT_WD-1:0]               pkt_cnt,
  output logic                            err_orphan
);
  localparam int PW = $clog2(NUM_REQ);
  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, pick;
  logic [PW-1:0]       gidx_q, gidx_d, rr_q, rr_d, pick_idx;
  logic [CNT_WD-1:0]   pkt_q, pkt_d;
  logic                err_q, err_d, any_req, offer, gvalid, last_hs;
  axi_hdr_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i (valid_hdr),
    .ptr_i (rr_q),
    .pick_o(pick),
    .idx_o (pick_idx),
    .any_o (any_req)
  );
  assign offer           = state_q == OFFER;
  assign gvalid          = valid_hdr[gidx_q];
  assign last_hs         = valid_out & ready_out & last_out;
  assign valid_insert    = offer & gvalid;
  assign ready_hdr       = offer ? grant_q & {NUM_REQ{ready_insert}} : '0;
  assign data_insert     = offer ? data_hdr[int'(gidx_q)*DATA_WD +: DATA_WD] : '0;
  assign keep_insert     = offer ? keep_hdr[int'(gidx_q)*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign byte_insert_cnt = offer ? cnt_hdr[int'(gidx_q)*BYTE_CNT_WD +: BYTE_CNT_WD] : '0;
  assign grant           = grant_q;
  assign pkt_cnt         = pkt_q;
  assign err_orphan      = err_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    pkt_d   = pkt_q;
    // A last beat only closes a packet once its header has been accepted.
    err_d   = err_q | (last_hs & (state_q != WAIT_LAST));
    if (state_q == IDLE && any_req) begin
      state_d = OFFER;
      grant_d = pick;
      gidx_d  = pick_idx;
    end
    if (offer && !gvalid) begin
      state_d = IDLE;
      grant_d = '0;
    end else if (offer && ready_insert) begin
      state_d = WAIT_LAST;
      rr_d    = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end
    if (state_q == WAIT_LAST && last_hs) begin
      state_d = IDLE;
      grant_d = '0;
      pkt_d   = pkt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb_axi_stream_header_arbiter: table vectors for the header mux plus a grant/data
// scoreboard popped on every insert-port handshake.
module tb_axi_stream_header_arbiter;
  localparam int N = 4, DW = 32, BW = 4, CW = 2, PW = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0]    valid_hdr = '0;
  logic [N*DW-1:0] data_hdr;
  logic [N*BW-1:0] keep_hdr;
  logic [N*CW-1:0] cnt_hdr;
  logic            ready_insert = 1'b0, valid_out = 1'b0, ready_out = 1'b0, last_out = 1'b0;
  logic [N-1:0]    ready_hdr, grant;
  logic            valid_insert, err_orphan;
  logic [DW-1:0]   data_insert;
  logic [BW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic [PW-1:0]   pkt_cnt;
  logic [DW-1:0]   hd[N];
  logic [BW-1:0]   hk[N];
  logic [CW-1:0]   hc[N];
  for (genvar i = 0; i < N; i++) begin : g_pk
    assign data_hdr[i*DW +: DW] = hd[i];
    assign keep_hdr[i*BW +: BW] = hk[i];
    assign cnt_hdr[i*CW +: CW]  = hc[i];
  end
  axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_REQ(N), .CNT_WD(PW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_hdr(valid_hdr), .data_hdr(data_hdr),
    .keep_hdr(keep_hdr), .cnt_hdr(cnt_hdr), .ready_hdr(ready_hdr),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
    .grant(grant), .pkt_cnt(pkt_cnt), .err_orphan(err_orphan)
  );
  int checks = 0, errors = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {logic [N-1:0] g; logic [DW-1:0] d; logic [BW-1:0] k;} exp_t;
  exp_t sb[$];
  task automatic push(int s);
    sb.push_back('{g: N'(1 << s), d: hd[s], k: hk[s]});
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_insert && ready_insert) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got grant %0h expected no handshake", grant);
      end else begin
        e = sb.pop_front();
        chk("sb_grant", 64'(grant), 64'(e.g));
        chk("sb_data", 64'(data_insert), 64'(e.d));
        chk("sb_keep", 64'(keep_insert), 64'(e.k));
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_hs;
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (valid_insert && ready_insert) break;
    end
    chk("hs_timeout", 64'(n == 30), 64'(0));
    step();
  endtask
  task automatic end_pkt;
    valid_out = 1'b1;
    ready_out = 1'b1;
    last_out  = 1'b0;
    step();
    step();
    last_out = 1'b1;
    step();
    valid_out = 1'b0;
    last_out  = 1'b0;
  endtask
  typedef struct {int src; logic [DW-1:0] d; logic [BW-1:0] k; logic [CW-1:0] c; logic [N-1:0] g;} vec_t;
  vec_t tv[4];
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      hd[i] = 32'hD0D0_0000 | DW'(i);
      hk[i] = 4'hF;
      hc[i] = CW'(i);
    end
    tv[0] = '{3, 32'h3333_0001, 4'b1000, 2'd1, 4'b1000};
    tv[1] = '{0, 32'h0000_F00D, 4'b0011, 2'd2, 4'b0001};
    tv[2] = '{1, 32'h1234_5678, 4'b0001, 2'd0, 4'b0010};
    tv[3] = '{3, 32'hCAFE_BABE, 4'b1111, 2'd3, 4'b1000};
    #12;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_valid", 64'(valid_insert), 0);
    chk("rst_ready", 64'(ready_hdr), 0);
    chk("rst_pkt", 64'(pkt_cnt), 0);
    chk("rst_err", 64'(err_orphan), 0);
    chk("rst_data", 64'(data_insert), 0);
    rst_n = 1'b1;
    step();
    ready_insert = 1'b1;
    ready_out = 1'b1;
    valid_hdr = 4'hF;
    push(0); push(1); push(2); push(3); push(0);
    repeat (5) begin
      wait_hs();
      end_pkt();
    end
    chk("rr_pkt", 64'(pkt_cnt), 5);
    chk("rr_grant_clear", 64'(grant), 0);
    valid_hdr = '0;
    ready_insert = 1'b0;
    hd[2] = 32'hAABB_CC33;
    hk[2] = 4'b0111;
    hc[2] = 2'd3;
    valid_hdr = 4'b0100;
    step();
    chk("mux_valid", 64'(valid_insert), 1);
    chk("mux_data", 64'(data_insert), 64'h AABB_CC33);
    chk("mux_keep", 64'(keep_insert), 64'b0111);
    chk("mux_cnt", 64'(byte_insert_cnt), 3);
    chk("mux_ready0", 64'(ready_hdr), 0);
    push(2);
    ready_insert = 1'b1;
    #1;
    chk("mux_ready1", 64'(ready_hdr), 64'b0100);
    wait_hs();
    chk("wl_valid", 64'(valid_insert), 0);
    chk("wl_data", 64'(data_insert), 0);
    chk("wl_ready", 64'(ready_hdr), 0);
    chk("wl_grant", 64'(grant), 64'b0100);
    end_pkt();
    valid_hdr = '0;
    ready_insert = 1'b0;
    for (int v = 0; v < 4; v++) begin
      hd[tv[v].src] = tv[v].d;
      hk[tv[v].src] = tv[v].k;
      hc[tv[v].src] = tv[v].c;
      valid_hdr = N'(1 << tv[v].src);
      step();
      chk("tv_grant", 64'(grant), 64'(tv[v].g));
      chk("tv_valid", 64'(valid_insert), 1);
      chk("tv_data", 64'(data_insert), 64'(tv[v].d));
      chk("tv_keep", 64'(keep_insert), 64'(tv[v].k));
      chk("tv_cnt", 64'(byte_insert_cnt), 64'(tv[v].c));
      chk("tv_ready0", 64'(ready_hdr), 0);
      valid_hdr = '0;
      ready_insert = 1'b1;
      #1;
      chk("tv_ready1", 64'(ready_hdr), 64'(tv[v].g));
      chk("tv_wd_valid", 64'(valid_insert), 0);
      step();
      chk("tv_wd_grant", 64'(grant), 0);
      chk("tv_wd_data", 64'(data_insert), 0);
      ready_insert = 1'b0;
    end
    valid_hdr = 4'hF;
    ready_insert = 1'b1;
    push(3);
    wait_hs();
    end_pkt();
    valid_hdr = 4'b0001;
    push(0);
    wait_hs();
    valid_hdr = 4'b0011;
    valid_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ready_out = i[0];
      last_out = ~i[0];
      step();
      chk("ho_ready", 64'(ready_hdr), 0);
      chk("ho_valid", 64'(valid_insert), 0);
    end
    ready_out = 1'b1;
    last_out = 1'b1;
    step();
    chk("ho_grant", 64'(grant), 0);
    chk("ho_pkt", 64'(pkt_cnt), 8);
    chk("ho_ready_idle", 64'(ready_hdr), 0);
    chk("ho_valid_idle", 64'(valid_insert), 0);
    valid_out = 1'b0;
    last_out = 1'b0;
    push(1);
    step();
    chk("ho_valid_up", 64'(valid_insert), 1);
    chk("ho_ready_up", 64'(ready_hdr), 64'b0010);
    wait_hs();
    end_pkt();
    valid_hdr = '0;
    chk("ho_err", 64'(err_orphan), 0);
    valid_out = 1'b1;
    ready_out = 1'b1;
    last_out = 1'b1;
    step();
    valid_out = 1'b0;
    last_out = 1'b0;
    chk("orph_err", 64'(err_orphan), 1);
    chk("orph_pkt", 64'(pkt_cnt), 9);
    chk("orph_grant", 64'(grant), 0);
    step();
    step();
    chk("orph_sticky", 64'(err_orphan), 1);
    valid_hdr = 4'b0100;
    push(2);
    wait_hs();
    valid_out = 1'b1;
    last_out = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 64'(grant), 0);
    chk("ar_valid", 64'(valid_insert), 0);
    chk("ar_ready", 64'(ready_hdr), 0);
    chk("ar_pkt", 64'(pkt_cnt), 0);
    chk("ar_err", 64'(err_orphan), 0);
    chk("ar_data", 64'(data_insert), 0);
    valid_out = 1'b0;
    valid_hdr = 4'b1100;
    push(2);
    #1;
    rst_n = 1'b1;
    wait_hs();
    end_pkt();
    chk("ar_pkt1", 64'(pkt_cnt), 1);
    push(3);
    step();
    valid_out = 1'b1;
    ready_out = 1'b1;
    last_out = 1'b1;
    step();
    valid_out = 1'b0;
    last_out = 1'b0;
    chk("sim_err", 64'(err_orphan), 1);
    chk("sim_pkt", 64'(pkt_cnt), 1);
    chk("sim_grant", 64'(grant), 64'b1000);
    chk("sim_valid", 64'(valid_insert), 0);
    valid_hdr = '0;
    end_pkt();
    chk("sim_pkt2", 64'(pkt_cnt), 2);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
